// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage load/store unit.
//   lsu_state_t : transaction FSM states (IDLE, REQ, RESP)
//   F3_*        : funct3 access size/sign encodings
//   RS_LOAD     : rsltSrc encoding that marks a load
//   f3_legal()  : funct3 legality check for loads and stores
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_LOAD = 2'b01;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data lane select and extension.
//   rdata_i  [31:0] : raw word returned by data memory
//   addr_i   [1:0]  : byte offset of the access
//   funct3_i [2:0]  : access size and sign
//   data_o   [31:0] : aligned, sign- or zero-extended load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfword accesses are aligned, so addr_i[1] alone picks the lane.
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit.
//   EX/MEM inputs : regWrtm, memWrtm, rsltSrcm, funct3m, aluRsltm, wrtDm,
//                   pc4m, ujWrtBckm, rdm
//   Data bus      : dReq/dWe/dAddr/dWdata/dBe out, dGnt/dRvalid/dRdata in
//   Pipeline      : stallM freezes upstream while an access is outstanding
//   MEM/WB outputs: regWrtw, rsltSrcw, aluRsltw, rdDataw, pc4w, ujWrtBckw,
//                   rdw, excw
module mem_lsu
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regWrtm,
  input  logic            memWrtm,
  input  logic [1:0]      rsltSrcm,
  input  logic [2:0]      funct3m,
  input  logic [XLEN-1:0] aluRsltm,
  input  logic [XLEN-1:0] wrtDm,
  input  logic [XLEN-1:0] pc4m,
  input  logic [XLEN-1:0] ujWrtBckm,
  input  logic [4:0]      rdm,
  output logic            dReq,
  output logic            dWe,
  output logic [XLEN-1:0] dAddr,
  output logic [XLEN-1:0] dWdata,
  output logic [3:0]      dBe,
  input  logic            dGnt,
  input  logic            dRvalid,
  input  logic [XLEN-1:0] dRdata,
  output logic            stallM,
  output logic            regWrtw,
  output logic [1:0]      rsltSrcw,
  output logic [XLEN-1:0] aluRsltw,
  output logic [XLEN-1:0] rdDataw,
  output logic [XLEN-1:0] pc4w,
  output logic [XLEN-1:0] ujWrtBckw,
  output logic [4:0]      rdw,
  output logic            excw
);

  lsu_state_t state_q, state_d;

  logic            is_load, acc, misaligned, illegal, bad, done;
  logic [1:0]      off;
  logic [3:0]      be_raw;
  logic [XLEN-1:0] load_val;

  logic            regWrt_q, exc_q;
  logic [1:0]      rsltSrc_q;
  logic [XLEN-1:0] aluRslt_q, rdData_q, pc4_q, ujWrtBck_q;
  logic [4:0]      rd_q;

  assign off     = aluRsltm[1:0];
  assign is_load = (rsltSrcm == RS_LOAD);
  assign acc     = memWrtm | is_load;

  always_comb begin
    misaligned = 1'b0;
    case (funct3m[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal = ~f3_legal(memWrtm, funct3m);
  assign bad     = acc & (misaligned | illegal);

  // Store formatting: replicate the data so every lane carries it and let
  // the byte enables pick the lanes that are really written.
  always_comb begin
    be_raw = 4'b1111;
    dWdata = wrtDm;
    case (funct3m[1:0])
      2'b00: begin
        be_raw = 4'b0001 << off;
        dWdata = {4{wrtDm[7:0]}};
      end
      2'b01: begin
        be_raw = 4'b0011 << off;
        dWdata = {2{wrtDm[15:0]}};
      end
      default: begin
        be_raw = 4'b1111;
        dWdata = wrtDm;
      end
    endcase
  end

  assign dAddr = {aluRsltm[XLEN-1:2], 2'b00};
  assign dWe   = memWrtm & ~rst;
  assign dBe   = rst ? 4'b0000 : be_raw;

  // done: the instruction currently in MEM retires at the coming edge.
  always_comb begin
    state_d = state_q;
    dReq    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        dReq = acc & ~bad;
        if (!acc || bad) begin
          done = 1'b1;
        end else if (memWrtm) begin
          if (dGnt) done = 1'b1;
          else      state_d = REQ;
        end else begin
          state_d = dGnt ? RESP : REQ;
        end
      end
      REQ: begin
        dReq = 1'b1;
        if (dGnt) begin
          if (memWrtm) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dRvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      dReq    = 1'b0;
      state_d = IDLE;
    end
  end

  assign stallM = ~done & ~rst;

  mem_load_align u_align (
    .rdata_i  (dRdata),
    .addr_i   (off),
    .funct3_i (funct3m),
    .data_o   (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      regWrt_q   <= 1'b0;
      exc_q      <= 1'b0;
      rsltSrc_q  <= 2'b00;
      aluRslt_q  <= '0;
      rdData_q   <= '0;
      pc4_q      <= '0;
      ujWrtBck_q <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      if (done) begin
        regWrt_q   <= regWrtm & ~bad;
        exc_q      <= bad;
        rsltSrc_q  <= rsltSrcm;
        aluRslt_q  <= aluRsltm;
        pc4_q      <= pc4m;
        ujWrtBck_q <= ujWrtBckm;
        rd_q       <= rdm;
        // Only a load retiring out of RESP carries valid memory data.
        if (state_q == RESP) rdData_q <= load_val;
      end else begin
        // Bubble: control cleared, data fields keep their last value.
        regWrt_q  <= 1'b0;
        exc_q     <= 1'b0;
        rsltSrc_q <= 2'b00;
      end
    end
  end

  assign regWrtw   = regWrt_q;
  assign excw      = exc_q;
  assign rsltSrcw  = rsltSrc_q;
  assign aluRsltw  = aluRslt_q;
  assign rdDataw   = rdData_q;
  assign pc4w      = pc4_q;
  assign ujWrtBckw = ujWrtBck_q;
  assign rdw       = rd_q;

endmodule
